pipeline_ctrl: RTL and testbench

Hazard and sequencing controller for the four-stage (IF, ID, EX, WB) processor pipeline. It tracks in-flight register writes in a two-entry scoreboard and stalls ID on read-after-write hazards. It holds fetch while a branch or jump drains to WB, where the branch decision resolves. It drives PC enable, the IF/ID enable/flush and the ID/EX bubble, and keeps stall and flush statistics.

---
 rtl/pipeline_ctrl.sv | 131 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the IF/ID/EX/WB pipeline: a two-entry
// write scoreboard drives RAW stalls, and a small FSM drains branches to WB.
module pipeline_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [5:0]       id_rs,
    input  logic [5:0]       id_rt,
    input  logic [5:0]       id_rd,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_regwrt,
    input  logic             id_is_ctrl,
    input  logic             wb_redirect,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             id_valid,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             ctrl_err
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        WAIT_EX = 2'd1,
        WAIT_WB = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic             sb_ex_vld, sb_wb_vld;
    logic [5:0]       sb_ex_rd, sb_wb_rd;
    logic             id_valid_q;
    logic [CNT_W-1:0] stall_q, flush_q;
    logic             err_q;

    logic rs_hit, rt_hit, hazard, issue;
    logic pc_en_c, ifid_en_c, ifid_flush_c, idex_bubble_c, stall_c;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v)
            return v;
        return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // No forwarding: a producer still in EX or WB blocks the read.
    assign rs_hit = (sb_ex_vld && (id_rs == sb_ex_rd)) || (sb_wb_vld && (id_rs == sb_wb_rd));
    assign rt_hit = (sb_ex_vld && (id_rt == sb_ex_rd)) || (sb_wb_vld && (id_rt == sb_wb_rd));
    assign hazard = id_valid_q && ((id_uses_rs && rs_hit) || (id_uses_rt && rt_hit));
    assign issue  = id_valid_q && (state == RUN) && !hazard;

    always_comb begin
        state_nxt     = state;
        pc_en_c       = 1'b0;
        ifid_en_c     = 1'b0;
        ifid_flush_c  = 1'b0;
        idex_bubble_c = 1'b1;
        stall_c       = 1'b0;
        case (state)
            RUN: begin
                if (hazard) begin
                    stall_c = 1'b1;
                end else if (issue && id_is_ctrl) begin
                    ifid_flush_c  = 1'b1;
                    idex_bubble_c = 1'b0;
                    state_nxt     = WAIT_EX;
                end else begin
                    pc_en_c       = 1'b1;
                    ifid_en_c     = 1'b1;
                    idex_bubble_c = !issue;
                end
            end
            WAIT_EX: begin
                ifid_flush_c = 1'b1;
                state_nxt    = WAIT_WB;
            end
            WAIT_WB: begin
                pc_en_c      = 1'b1;
                ifid_flush_c = 1'b1;
                state_nxt    = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= RUN;
            sb_ex_vld  <= 1'b0;
            sb_wb_vld  <= 1'b0;
            id_valid_q <= 1'b0;
            stall_q    <= '0;
            flush_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state     <= state_nxt;
            sb_wb_vld <= sb_ex_vld;
            sb_ex_vld <= issue && id_regwrt;
            if (ifid_flush_c)
                id_valid_q <= 1'b0;
            else if (ifid_en_c)
                id_valid_q <= 1'b1;
            if (stall_c)
                stall_q <= sat_inc(stall_q);
            if (ifid_flush_c)
                flush_q <= sat_inc(flush_q);
            if (wb_redirect && (state != WAIT_WB))
                err_q <= 1'b1;
        end
    end

    // Destination fields are only meaningful alongside their valid bits.
    always_ff @(posedge clock) begin
        sb_wb_rd <= sb_ex_rd;
        sb_ex_rd <= id_rd;
    end

    // Reset forces the outputs immediately, before the first reset edge lands.
    assign pc_en       = reset_n && pc_en_c;
    assign ifid_en     = reset_n && ifid_en_c;
    assign ifid_flush  = !reset_n || ifid_flush_c;
    assign idex_bubble = !reset_n || idex_bubble_c;
    assign id_valid    = reset_n && id_valid_q;
    assign stall_cnt   = reset_n ? stall_q : '0;
    assign flush_cnt   = reset_n ? flush_q : '0;
    assign ctrl_err    = reset_n && err_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: reset forcing, RAW stalls, branch drain,
// stray redirect and counter saturation (counters built 4 bits wide).
module tb_pipeline_ctrl;

    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [5:0]    id_rs, id_rt, id_rd;
    logic          id_uses_rs, id_uses_rt, id_regwrt, id_is_ctrl, wb_redirect;
    logic          pc_en, ifid_en, ifid_flush, idex_bubble, id_valid, ctrl_err;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int total = 0;
    int bad   = 0;

    pipeline_ctrl #(.CNT_W(CW)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_rd       (id_rd),
        .id_uses_rs  (id_uses_rs),
        .id_uses_rt  (id_uses_rt),
        .id_regwrt   (id_regwrt),
        .id_is_ctrl  (id_is_ctrl),
        .wb_redirect (wb_redirect),
        .pc_en       (pc_en),
        .ifid_en     (ifid_en),
        .ifid_flush  (ifid_flush),
        .idex_bubble (idex_bubble),
        .id_valid    (id_valid),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt),
        .ctrl_err    (ctrl_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic pc, input logic fl, input logic bub);
        chk({tag, ".pc_en"}, 32'(pc_en), 32'(pc));
        chk({tag, ".ifid_flush"}, 32'(ifid_flush), 32'(fl));
        chk({tag, ".idex_bubble"}, 32'(idex_bubble), 32'(bub));
    endtask

    task automatic chk_forced(input string tag);
        chk_out(tag, 1'b0, 1'b1, 1'b1);
        chk({tag, ".ifid_en"}, 32'(ifid_en), 0);
        chk({tag, ".id_valid"}, 32'(id_valid), 0);
        chk({tag, ".stall_cnt"}, 32'(stall_cnt), 0);
        chk({tag, ".flush_cnt"}, 32'(flush_cnt), 0);
        chk({tag, ".ctrl_err"}, 32'(ctrl_err), 0);
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic instr(input logic [5:0] rs, input logic [5:0] rt, input logic [5:0] rd,
                         input logic urs, input logic urt, input logic wr, input logic ctl);
        id_rs      = rs;
        id_rt      = rt;
        id_rd      = rd;
        id_uses_rs = urs;
        id_uses_rt = urt;
        id_regwrt  = wr;
        id_is_ctrl = ctl;
    endtask

    task automatic idle();
        instr(6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        wb_redirect = 1'b0;
    endtask

    // Leaves the DUT one cycle past release, with id_valid=1 and ID free to load.
    task automatic do_reset();
        reset_n = 1'b0;
        idle();
        cyc();
        reset_n = 1'b1;
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-up reset and release
        reset_n = 1'b0;
        idle();
        cyc();
        cyc();
        #1;
        chk_forced("rst_init");
        reset_n = 1'b1;
        #1;
        chk_out("rel0", 1'b1, 1'b0, 1'b1);
        chk("rel0.ifid_en", 32'(ifid_en), 1);
        chk("rel0.id_valid", 32'(id_valid), 0);

        // Control instruction that writes r9, then reset held 3 cycles in WAIT_EX
        cyc();
        instr(6'd40, 6'd0, 6'd9, 1'b1, 1'b0, 1'b1, 1'b1);
        #1;
        chk("ctl.id_valid", 32'(id_valid), 1);
        chk_out("ctl_iss", 1'b0, 1'b1, 1'b0);
        cyc();
        reset_n = 1'b0;
        idle();
        #1;
        chk_forced("rst_wx0");
        cyc();
        #1;
        chk_forced("rst_wx1");
        cyc();
        #1;
        chk_forced("rst_wx2");
        cyc();
        reset_n = 1'b1;
        #1;
        chk_out("post0", 1'b1, 1'b0, 1'b1);
        chk("post0.ifid_en", 32'(ifid_en), 1);
        chk("post0.id_valid", 32'(id_valid), 0);
        chk("post0.stall_cnt", 32'(stall_cnt), 0);
        chk("post0.flush_cnt", 32'(flush_cnt), 0);
        cyc();
        instr(6'd9, 6'd9, 6'd1, 1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        chk_out("post1_r9", 1'b1, 1'b0, 1'b0);

        // Independent stream
        do_reset();
        for (int n = 1; n <= 6; n++) begin
            instr(6'(n + 10), 6'(n + 20), 6'(n), 1'b1, 1'b1, 1'b1, 1'b0);
            #1;
            chk_out("indep", 1'b1, 1'b0, 1'b0);
            cyc();
        end
        idle();
        #1;
        chk("indep.stall_cnt", 32'(stall_cnt), 0);

        // Adjacent RAW on rs
        do_reset();
        instr(6'd20, 6'd0, 6'd5, 1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        chk_out("rawrs_a", 1'b1, 1'b0, 1'b0);
        cyc();
        instr(6'd5, 6'd21, 6'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        chk_out("rawrs_s1", 1'b0, 1'b0, 1'b1);
        chk("rawrs_s1.ifid_en", 32'(ifid_en), 0);
        cyc();
        #1;
        chk_out("rawrs_s2", 1'b0, 1'b0, 1'b1);
        cyc();
        #1;
        chk_out("rawrs_iss", 1'b1, 1'b0, 1'b0);
        chk("rawrs.stall_cnt", 32'(stall_cnt), 2);

        // Adjacent RAW on rt only
        do_reset();
        instr(6'd20, 6'd0, 6'd5, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc();
        instr(6'd30, 6'd5, 6'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        chk_out("rawrt_s1", 1'b0, 1'b0, 1'b1);
        cyc();
        #1;
        chk_out("rawrt_s2", 1'b0, 1'b0, 1'b1);
        cyc();
        #1;
        chk_out("rawrt_iss", 1'b1, 1'b0, 1'b0);
        chk("rawrt.stall_cnt", 32'(stall_cnt), 2);

        // Distance-2 RAW
        do_reset();
        instr(6'd20, 6'd0, 6'd7, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc();
        instr(6'd21, 6'd0, 6'd8, 1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        chk_out("d2_c", 1'b1, 1'b0, 1'b0);
        cyc();
        instr(6'd7, 6'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk_out("d2_s1", 1'b0, 1'b0, 1'b1);
        cyc();
        #1;
        chk_out("d2_iss", 1'b1, 1'b0, 1'b0);
        chk("d2.stall_cnt", 32'(stall_cnt), 1);

        // Same pattern, sources unused
        do_reset();
        instr(6'd20, 6'd0, 6'd7, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc();
        instr(6'd21, 6'd0, 6'd8, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc();
        instr(6'd7, 6'd7, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk_out("d2nu_iss", 1'b1, 1'b0, 1'b0);
        cyc();
        #1;
        chk("d2nu.stall_cnt", 32'(stall_cnt), 0);

        // Taken branch with redirect at t+2
        do_reset();
        instr(6'd22, 6'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        #1;
        chk_out("br_t0", 1'b0, 1'b1, 1'b0);
        cyc();
        idle();
        #1;
        chk_out("br_t1", 1'b0, 1'b1, 1'b1);
        cyc();
        wb_redirect = 1'b1;
        #1;
        chk_out("br_t2", 1'b1, 1'b1, 1'b1);
        cyc();
        wb_redirect = 1'b0;
        #1;
        chk_out("br_t3", 1'b1, 1'b0, 1'b1);
        chk("br_t3.ifid_en", 32'(ifid_en), 1);
        chk("br_t3.id_valid", 32'(id_valid), 0);
        chk("br_t3.flush_cnt", 32'(flush_cnt), 3);
        chk("br_t3.ctrl_err", 32'(ctrl_err), 0);
        cyc();
        #1;
        chk("br_t4.id_valid", 32'(id_valid), 1);

        // Jump-mem reading r3 right after a load into r3
        do_reset();
        instr(6'd23, 6'd0, 6'd3, 1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        chk_out("jm_ld", 1'b1, 1'b0, 1'b0);
        cyc();
        instr(6'd3, 6'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        #1;
        chk_out("jm_s1", 1'b0, 1'b0, 1'b1);
        cyc();
        #1;
        chk_out("jm_s2", 1'b0, 1'b0, 1'b1);
        cyc();
        #1;
        chk_out("jm_iss", 1'b0, 1'b1, 1'b0);
        cyc();
        idle();
        #1;
        chk_out("jm_wex", 1'b0, 1'b1, 1'b1);
        cyc();
        #1;
        chk_out("jm_wwb", 1'b1, 1'b1, 1'b1);
        cyc();
        #1;
        chk_out("jm_run", 1'b1, 1'b0, 1'b1);
        chk("jm.stall_cnt", 32'(stall_cnt), 2);
        chk("jm.flush_cnt", 32'(flush_cnt), 3);
        chk("jm.ctrl_err", 32'(ctrl_err), 0);

        // Stray redirect in RUN is sticky until reset
        wb_redirect = 1'b1;
        cyc();
        wb_redirect = 1'b0;
        #1;
        chk("stray.ctrl_err", 32'(ctrl_err), 1);
        cyc();
        cyc();
        #1;
        chk("stray_hold.ctrl_err", 32'(ctrl_err), 1);
        do_reset();
        #1;
        chk("stray_rst.ctrl_err", 32'(ctrl_err), 0);

        // Saturation: 10 producer/consumer pairs, 2 stalls each
        for (int p = 0; p < 7; p++) begin
            instr(6'd40, 6'd0, 6'd5, 1'b1, 1'b0, 1'b1, 1'b0);
            cyc();
            instr(6'd5, 6'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0);
            cyc();
            cyc();
            cyc();
        end
        #1;
        chk("sat14.stall_cnt", 32'(stall_cnt), 14);
        for (int p = 0; p < 3; p++) begin
            instr(6'd40, 6'd0, 6'd5, 1'b1, 1'b0, 1'b1, 1'b0);
            cyc();
            instr(6'd5, 6'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0);
            cyc();
            cyc();
            cyc();
        end
        idle();
        #1;
        chk("sat15.stall_cnt", 32'(stall_cnt), 15);
        chk("sat.flush_cnt", 32'(flush_cnt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
